// File: rtl/as_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : as_wb_arbiter
// Purpose  : Shares the single write port of the integer register file
//            between several writeback sources (ALU, load unit, mul/div).
//            Same-cycle requests are arbitrated combinationally over a
//            valid/ready handshake, and the winner is registered onto the
//            register file write port. The registered write doubles as a
//            one-cycle forwarding view. A saturating counter tracks cycles
//            with two or more requests.
// Ports    : clk_i        core clock, rising edge
//            rst_i        asynchronous active-high reset
//            req_valid_i  per-requester valid
//            req_ready_o  per-requester grant, one-hot or zero
//            req_addr_i   flattened destination registers, RWADDR_WIDTH each
//            req_data_i   flattened write data, REG_WIDTH each
//            we_o         register file write enable (0 for x0 writes)
//            waddr_o      register file write address
//            wdata_o      register file write data
//            fwd_valid_o  in-flight write visible to bypass logic (= we_o)
//            cnt_clr_i    synchronous clear of the contention counter
//            cont_cnt_o   saturating count of contention cycles
// Revision : 1.0 - initial release
// ============================================================================
module as_wb_arbiter #(
    parameter int NR_REQ       = 3,
    parameter int RR_EN        = 1,
    parameter int CNT_WIDTH    = 16,
    parameter int REG_WIDTH    = 64,
    parameter int RWADDR_WIDTH = 5
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NR_REQ-1:0]              req_valid_i,
    output logic [NR_REQ-1:0]              req_ready_o,
    input  logic [NR_REQ*RWADDR_WIDTH-1:0] req_addr_i,
    input  logic [NR_REQ*REG_WIDTH-1:0]    req_data_i,
    output logic                           we_o,
    output logic [RWADDR_WIDTH-1:0]        waddr_o,
    output logic [REG_WIDTH-1:0]           wdata_o,
    output logic                           fwd_valid_o,
    input  logic                           cnt_clr_i,
    output logic [CNT_WIDTH-1:0]           cont_cnt_o
);

    localparam int                    c_PTR_W   = $clog2(NR_REQ);
    localparam logic [c_PTR_W-1:0]    c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_PTR_W-1:0]    c_PTR_MAX = c_PTR_W'(NR_REQ - 1);
    localparam logic [NR_REQ-1:0]     c_REQ_ONE = NR_REQ'(1);
    localparam logic [CNT_WIDTH-1:0]  c_CNT_ONE = CNT_WIDTH'(1);

    logic [c_PTR_W-1:0]      r_ptr;
    logic                    r_we;
    logic [RWADDR_WIDTH-1:0] r_waddr;
    logic [REG_WIDTH-1:0]    r_wdata;
    logic [CNT_WIDTH-1:0]    r_cnt;

    logic [c_PTR_W-1:0]      w_ptr_nxt;
    logic                    w_we_nxt;
    logic [RWADDR_WIDTH-1:0] w_waddr_nxt;
    logic [REG_WIDTH-1:0]    w_wdata_nxt;
    logic [CNT_WIDTH-1:0]    w_cnt_nxt;

    logic                    w_found;
    logic [c_PTR_W-1:0]      w_gidx;
    logic                    w_xfer;
    logic [NR_REQ-1:0]       w_grant;
    logic                    w_multi;
    logic [RWADDR_WIDTH-1:0] w_sel_addr;
    logic [REG_WIDTH-1:0]    w_sel_data;

    // Walk the requesters in priority order; the first valid one wins.
    // In round-robin mode the order starts at r_ptr and wraps, otherwise
    // index 0 is always searched first.
    always_comb begin : p_arb
        int order_idx;
        order_idx = 0;
        w_found   = 1'b0;
        w_gidx    = '0;
        for (int k = 0; k < NR_REQ; k++) begin
            if (RR_EN != 0) begin
                order_idx = (int'(r_ptr) + k) % NR_REQ;
            end else begin
                order_idx = k;
            end
            for (int i = 0; i < NR_REQ; i++) begin
                if (!w_found && (order_idx == i) && req_valid_i[i]) begin
                    w_found = 1'b1;
                    w_gidx  = c_PTR_W'(i);
                end
            end
        end
    end

    // While reset is asserted nothing is granted, so requesters keep their
    // requests and re-present them afterwards.
    assign w_xfer = w_found & ~rst_i;

    always_comb begin : p_grant
        w_grant    = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (w_xfer && (w_gidx == c_PTR_W'(i))) begin
                w_grant[i] = 1'b1;
                w_sel_addr = req_addr_i[i*RWADDR_WIDTH +: RWADDR_WIDTH];
                w_sel_data = req_data_i[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    assign req_ready_o = w_grant;

    // Two or more valids: clearing the lowest set bit leaves something set.
    assign w_multi = |(req_valid_i & (req_valid_i - c_REQ_ONE));

    always_comb begin : p_next
        w_ptr_nxt   = r_ptr;
        w_we_nxt    = 1'b0;
        w_waddr_nxt = r_waddr;
        w_wdata_nxt = r_wdata;
        w_cnt_nxt   = r_cnt;

        if (w_xfer) begin
            // x0 writes are accepted and latched but never enable the port.
            w_we_nxt    = (w_sel_addr != '0);
            w_waddr_nxt = w_sel_addr;
            w_wdata_nxt = w_sel_data;
            if (RR_EN != 0) begin
                w_ptr_nxt = (w_gidx == c_PTR_MAX) ? '0 : (w_gidx + c_PTR_ONE);
            end
        end

        if (cnt_clr_i) begin
            w_cnt_nxt = '0;
        end else if (w_multi && !(&r_cnt)) begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_ptr   <= w_ptr_nxt;
            r_we    <= w_we_nxt;
            r_waddr <= w_waddr_nxt;
            r_wdata <= w_wdata_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign we_o        = r_we;
    assign fwd_valid_o = r_we;
    assign waddr_o     = r_waddr;
    assign wdata_o     = r_wdata;
    assign cont_cnt_o  = r_cnt;

endmodule
`default_nettype wire

// File: doc/as_wb_arbiter.md
# as_wb_arbiter

Shares the single write port of the integer register file (as_regfile) between several writeback sources: ALU, load unit and mul/div. It arbitrates same-cycle write requests over a valid/ready handshake and registers the winner onto the register file write port. It also drives a one-cycle forwarding view of the in-flight write and a saturating contention counter. It sits between the execute/memory stages and as_regfile.

## Interface

Parameters (reg_width, rwaddr_width come from as_pack):
- NR_REQ, 3, number of writeback requesters; legal range 2..8; index 0 is highest priority when RR_EN=0.
- RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
- CNT_WIDTH, 16, width of the contention counter.

Ports:
- clk_i  in  1  core clock; all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  NR_REQ  request valid, one bit per requester.
- req_ready_o  out  NR_REQ  grant/accept, one-hot or zero.
- req_addr_i  in  NR_REQ*rwaddr_width  flattened destination register; requester i occupies bits [i*rwaddr_width +: rwaddr_width].
- req_data_i  in  NR_REQ*reg_width  flattened write data, same packing.
- we_o  out  1  register file write enable; connects to we_i.
- waddr_o  out  rwaddr_width  register file write address.
- wdata_o  out  reg_width  register file write data.
- fwd_valid_o  out  1  in-flight write is visible to bypass logic; equals we_o.
- cnt_clr_i  in  1  synchronous clear of the contention counter.
- cont_cnt_o  out  CNT_WIDTH  saturating count of contention cycles.

## Operation

- Handshake: transfer on requester i when req_valid_i[i] & req_ready_o[i].
  - A requester holds valid, addr and data stable until its transfer.
  - Valid must not depend on ready.
  - req_ready_o may depend combinationally on req_valid_i.
- Arbitration is combinational each cycle.
  - Exactly one ready bit is set when any valid bit is high; all ready bits are 0 otherwise.
  - A request is never granted without its valid.
- Fixed priority (RR_EN=0): the lowest valid index wins.
- Round-robin (RR_EN=1):
  - The pointer ptr (clog2(NR_REQ) bits, reset 0) marks the highest-priority index.
  - Search order is ptr, ptr+1, … mod NR_REQ.
  - After a transfer on index g, ptr <= (g+1) mod NR_REQ, wrapping from NR_REQ-1 to 0.
  - ptr does not change on cycles with no transfer.
- Output stage: on a transfer, register waddr_o <= addr and wdata_o <= data.
  - we_o <= 1, except when addr == 0.
- x0 writes: the request is accepted (ready=1) and ptr advances, but we_o stays 0.
  - waddr_o and wdata_o still update.
- No-transfer cycle: we_o <= 0. waddr_o and wdata_o hold their last values.
- Contention counter:
  - Increments by 1 on each cycle where two or more req_valid_i bits are high.
  - Saturates at all-ones; it never wraps.
  - cnt_clr_i has priority over increment: the counter reads 0 the next cycle.
- The block never stalls. At most one write is accepted per cycle, and no request is buffered beyond the output register.

## Timing

- Reset (asynchronous, effective immediately) forces:
  - we_o=0, fwd_valid_o=0, waddr_o=0, wdata_o=0, cont_cnt_o=0, ptr=0.
  - req_ready_o is combinational and is 0 while all valids are 0.
- Latency: a transfer in cycle N gives we_o/waddr_o/wdata_o in cycle N+1. as_regfile commits the write at the end of cycle N+1, so it is readable in N+2.
  - Bypass logic uses fwd_valid_o/waddr_o/wdata_o during N+1.
- Back-to-back transfers give back-to-back we_o pulses. There are no bubble cycles.
- Reset asserted mid-operation:
  - The pending output-stage write is dropped: we_o=0 immediately and no write reaches the regfile.
  - In-flight requests are neither granted nor lost; requesters must re-present them after reset.
- Simultaneous events: two requesters targeting the same register produce two sequential writes in grant order. The last write wins in the register file.
- Round-robin fairness: a continuously valid requester is granted within NR_REQ cycles.

## Test plan

- Reset: assert rst_i mid-cycle with we_o=1 → we_o, waddr_o, wdata_o, cont_cnt_o drop to 0 asynchronously; ptr=0.
- Single request: req 1 valid, addr=5, data=64'hDEAD_BEEF in cycle N → ready[1]=1 in N; we_o=1, waddr_o=5, wdata_o=64'hDEAD_BEEF in N+1; we_o=0 in N+2.
- Round-robin, RR_EN=1, NR_REQ=3, all three valid for 6 cycles → grant order 0,1,2,0,1,2; cont_cnt_o=6 afterwards.
- Fixed priority, RR_EN=0, reqs 0 and 2 valid for 3 cycles → req 0 granted all 3 cycles; ready[2]=0 throughout.
- x0 write: req 0 addr=0, data=1 → ready[0]=1; we_o stays 0 next cycle; ptr advances to 1.
- Counter: CNT_WIDTH=4 with 20 contention cycles → saturates at 15; cnt_clr_i pulse → 0 next cycle, even with contention present.
